// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master core between two requesters.
// Each wait state of a transaction is bounded by TIMEOUT cycles; all outputs are registered.
module i2c_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_i,
    input  logic [6:0] addr0_i,
    input  logic [7:0] data0_i,
    input  logic       req1_i,
    input  logic [6:0] addr1_i,
    input  logic [7:0] data1_i,
    output logic       gnt0_o,
    output logic       gnt1_o,
    output logic       done0_o,
    output logic       done1_o,
    output logic       err_o,
    output logic       busy_o,
    input  logic       i2c_ready_i,
    output logic [6:0] i2c_address_o,
    output logic [7:0] i2c_data_o,
    output logic       i2c_start_o
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic              r_owner;
    logic [6:0]        r_addr;
    logic [7:0]        r_data;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic              r_err;
    logic              r_busy;
    logic              r_start;

    state_e            w_state_nxt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic              w_owner_nxt;
    logic [6:0]        w_addr_nxt;
    logic [7:0]        w_data_nxt;
    logic              w_gnt0_nxt;
    logic              w_gnt1_nxt;
    logic              w_done0_nxt;
    logic              w_done1_nxt;
    logic              w_err_nxt;
    logic              w_start_nxt;
    logic              w_pick1;
    logic              w_expire;
    logic [CntW-1:0]   w_cnt_dec;

    // The current wait cycle is the last one allowed when the counter is down to 1.
    assign w_expire  = (r_cnt <= CntW'(1));
    assign w_cnt_dec = w_expire ? '0 : (r_cnt - CntW'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
        w_done0_nxt = 1'b0;
        w_done1_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_start_nxt = 1'b0;
        w_pick1     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i2c_ready_i && (req0_i || req1_i)) begin
                    // On a tie the requester that did not own the last transaction wins.
                    w_pick1     = (req0_i && req1_i) ? ~r_owner : req1_i;
                    w_owner_nxt = w_pick1;
                    w_addr_nxt  = w_pick1 ? addr1_i : addr0_i;
                    w_data_nxt  = w_pick1 ? data1_i : data0_i;
                    w_gnt0_nxt  = ~w_pick1;
                    w_gnt1_nxt  = w_pick1;
                    w_state_nxt = StLaunch;
                end
            end
            StLaunch: begin
                w_start_nxt = 1'b1;
                w_cnt_nxt   = CntW'(TIMEOUT);
                w_state_nxt = StWaitBusy;
            end
            StWaitBusy: begin
                if (!i2c_ready_i) begin
                    w_cnt_nxt   = CntW'(TIMEOUT);
                    w_state_nxt = StWaitDone;
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            StWaitDone: begin
                if (i2c_ready_i) begin
                    w_done0_nxt = ~r_owner;
                    w_done1_nxt = r_owner;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StIdle;
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_owner <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_gnt0  <= w_gnt0_nxt;
            r_gnt1  <= w_gnt1_nxt;
            r_done0 <= w_done0_nxt;
            r_done1 <= w_done1_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != StIdle);
            r_start <= w_start_nxt;
        end
    end

    assign gnt0_o        = r_gnt0;
    assign gnt1_o        = r_gnt1;
    assign done0_o       = r_done0;
    assign done1_o       = r_done1;
    assign err_o         = r_err;
    assign busy_o        = r_busy;
    assign i2c_address_o = r_addr;
    assign i2c_data_o    = r_data;
    assign i2c_start_o   = r_start;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: two instances (default and short TIMEOUT) share stimulus and are
// checked every cycle against a transaction-level model of grant order and outcome timing.
module tb_i2c_arbiter;

    localparam int TShort   = 8;
    localparam int TDefault = 1024;

    logic            clk;
    logic            rst;
    logic            req0;
    logic            req1;
    logic            ready;
    logic [6:0]      addr0;
    logic [6:0]      addr1;
    logic [7:0]      data0;
    logic [7:0]      data1;
    logic [1:0]      gnt0;
    logic [1:0]      gnt1;
    logic [1:0]      done0;
    logic [1:0]      done1;
    logic [1:0]      err;
    logic [1:0]      busy;
    logic [1:0]      start;
    logic [1:0][6:0] i2c_addr;
    logic [1:0][7:0] i2c_data;

    int         errors = 0;
    int         checks = 0;
    bit         last_owner;
    logic [6:0] exp_addr;
    logic [7:0] exp_data;

    i2c_arbiter u_dut_def (
        .clk           (clk),
        .rst           (rst),
        .req0_i        (req0),
        .addr0_i       (addr0),
        .data0_i       (data0),
        .req1_i        (req1),
        .addr1_i       (addr1),
        .data1_i       (data1),
        .gnt0_o        (gnt0[0]),
        .gnt1_o        (gnt1[0]),
        .done0_o       (done0[0]),
        .done1_o       (done1[0]),
        .err_o         (err[0]),
        .busy_o        (busy[0]),
        .i2c_ready_i   (ready),
        .i2c_address_o (i2c_addr[0]),
        .i2c_data_o    (i2c_data[0]),
        .i2c_start_o   (start[0])
    );

    i2c_arbiter #(.TIMEOUT(TShort)) u_dut_short (
        .clk           (clk),
        .rst           (rst),
        .req0_i        (req0),
        .addr0_i       (addr0),
        .data0_i       (data0),
        .req1_i        (req1),
        .addr1_i       (addr1),
        .data1_i       (data1),
        .gnt0_o        (gnt0[1]),
        .gnt1_o        (gnt1[1]),
        .done0_o       (done0[1]),
        .done1_o       (done1[1]),
        .err_o         (err[1]),
        .busy_o        (busy[1]),
        .i2c_ready_i   (ready),
        .i2c_address_o (i2c_addr[1]),
        .i2c_data_o    (i2c_data[1]),
        .i2c_start_o   (start[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {gnt0, gnt1, start, done0, done1, err, busy, address, data}
    function automatic logic [21:0] observed(int i);
        return {gnt0[i], gnt1[i], start[i], done0[i], done1[i], err[i], busy[i],
                i2c_addr[i], i2c_data[i]};
    endfunction

    // Cycle (counted from the grant cycle = 1) in which done or err appears.
    function automatic int outcome_cycle(int a, int l, int t);
        if (a >= t) return t + 2;
        if (l > t) return a + t + 3;
        return a + l + 3;
    endfunction

    function automatic bit outcome_err(int a, int l, int t);
        return (a >= t) || (l > t);
    endfunction

    function automatic logic [6:0] exp_flags(int j, int oc, bit e, bit own);
        logic [6:0] f;
        f = 7'b0;
        if (j == 1)       f = {~own, own, 5'b00001};
        else if (j == 2)  f = 7'b0010001;
        else if (j < oc)  f = 7'b0000001;
        else if (j == oc) f = e ? 7'b0000010 : {3'b000, ~own, own, 2'b00};
        return f;
    endfunction

    // One transaction: core keeps ready high for `a` wait cycles after start, then low for `l`.
    // mode 0 drops requests after grant, 1 holds them, 2 scrambles requests and operands.
    task automatic run_txn(input string name, input bit r0, input bit r1, input int a,
                           input int l, input int mode, input logic [6:0] a0,
                           input logic [7:0] d0, input logic [6:0] a1, input logic [7:0] d1);
        int          oc [2];
        bit          e [2];
        int          first;
        int          last;
        bit          own;
        logic [21:0] got;
        logic [21:0] want;
        own        = (r0 && r1) ? !last_owner : r1;
        last_owner = own;
        exp_addr   = own ? a1 : a0;
        exp_data   = own ? d1 : d0;
        oc[0] = outcome_cycle(a, l, TDefault);
        e[0]  = outcome_err(a, l, TDefault);
        oc[1] = outcome_cycle(a, l, TShort);
        e[1]  = outcome_err(a, l, TShort);
        first = (oc[0] < oc[1]) ? oc[0] : oc[1];
        last  = (oc[0] > oc[1]) ? oc[0] : oc[1];
        addr0 = a0;
        data0 = d0;
        addr1 = a1;
        data1 = d1;
        req0  = r0;
        req1  = r1;
        ready = 1'b1;
        for (int j = 1; j <= last; j++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                want = {exp_flags(j, oc[i], e[i], own), exp_addr, exp_data};
                got  = observed(i);
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s dut%0d cycle %0d: got %h, expected %h",
                             name, i, j, got, want);
                end
            end
            ready = !(j >= a + 2 && j < a + 2 + l);
            if (j >= first || mode == 0) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end else if (mode == 2) begin
                req0  = 1'($urandom_range(0, 1));
                req1  = 1'($urandom_range(0, 1));
                addr0 = 7'($urandom);
                data0 = 8'($urandom);
                addr1 = 7'($urandom);
                data1 = 8'($urandom);
            end
        end
    endtask

    // Idle cycles in which nothing may be granted (no request or core not ready).
    task automatic idle_cycles(input string name, input int n, input bit r0, input bit r1,
                               input bit rdy);
        logic [21:0] got;
        req0  = r0;
        req1  = r1;
        ready = rdy;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                got = observed(i);
                checks++;
                if (got !== {7'b0, exp_addr, exp_data}) begin
                    errors++;
                    $display("FAIL %s dut%0d cycle %0d: got %h, expected %h",
                             name, i, j, got, {7'b0, exp_addr, exp_data});
                end
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        ready = 1'b1;
        addr0 = 7'h7f;
        data0 = 8'hff;
        addr1 = 7'h7f;
        data1 = 8'hff;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (observed(i) !== 22'b0) begin
                errors++;
                $display("FAIL reset dut%0d: got %h, expected 0", i, observed(i));
            end
        end
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        last_owner = 1'b1;
        exp_addr   = 7'h00;
        exp_data   = 8'h00;
        idle_cycles("reset_idle", 3, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_tie();
        for (int k = 0; k < 3; k++)
            run_txn("tie", 1'b1, 1'b1, 1, 2, 1, 7'h12, 8'h34, 7'h33, 8'h44);
    endtask

    task automatic test_single();
        run_txn("single", 1'b1, 1'b0, 2, 10, 0, 7'h72, 8'hab, 7'h01, 8'h02);
        idle_cycles("single_after", 3, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_ready_low();
        idle_cycles("ready_low", 5, 1'b0, 1'b1, 1'b0);
        run_txn("ready_low_gnt", 1'b0, 1'b1, 0, 1, 0, 7'h11, 8'h22, 7'h5c, 8'hc5);
    endtask

    task automatic test_timeout();
        run_txn("timeout_busy", 1'b1, 1'b0, 20, 1, 0, 7'h40, 8'h04, 7'h00, 8'h00);
        run_txn("timeout_done", 1'b0, 1'b1, 1, 12, 0, 7'h00, 8'h00, 7'h2a, 8'ha2);
    endtask

    task automatic test_reset_mid();
        logic [21:0] got;
        addr0 = 7'h15;
        data0 = 8'h5a;
        req0  = 1'b1;
        req1  = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            got = observed(i);
            checks++;
            if (got !== {7'b1000001, 7'h15, 8'h5a}) begin
                errors++;
                $display("FAIL reset_mid_gnt dut%0d: got %h, expected %h",
                         i, got, {7'b1000001, 7'h15, 8'h5a});
            end
        end
        req0 = 1'b0;
        @(negedge clk);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (observed(i) !== 22'b0) begin
                errors++;
                $display("FAIL reset_mid_async dut%0d: got %h, expected 0", i, observed(i));
            end
        end
        @(negedge clk);
        rst        = 1'b1;
        last_owner = 1'b1;
        exp_addr   = 7'h00;
        exp_data   = 8'h00;
        for (int j = 0; j < 12; j++) begin
            idle_cycles("reset_mid_after", 1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        run_txn("reset_mid_tie", 1'b1, 1'b1, 0, 1, 0, 7'h0a, 8'hb0, 7'h0c, 8'hd0);
    endtask

    task automatic test_random();
        int pat;
        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 3) == 0)
                idle_cycles("rand_gap", int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), 1'b0);
            pat = int'($urandom_range(1, 3));
            run_txn("random", pat[0], pat[1], int'($urandom_range(0, 10)),
                    int'($urandom_range(1, 11)), int'($urandom_range(0, 2)),
                    7'($urandom), 8'($urandom), 7'($urandom), 8'($urandom));
        end
        idle_cycles("random_end", 2, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_ready_low();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
